// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported word memory between fetch (A) and load/store (B).
// Define MEM_PORT_ARB_FIXED_PRIO_EN for fixed B-wins priority; default is round-robin.
module mem_port_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [31:0]   a_addr,
   input  logic [DW-1:0] a_wdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [31:0]   b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          a_gnt,
   output logic          b_gnt,
   output logic          a_rvalid,
   output logic          b_rvalid,
   output logic [DW-1:0] a_rdata,
   output logic [DW-1:0] b_rdata,
   output logic          a_err,
   output logic          b_err,
   output logic          mem_we,
   output logic [31:0]   mem_raddr,
   output logic [31:0]   mem_waddr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   logic          w_a_win;
   logic          w_b_win;
   logic          w_a_gnt;
   logic          w_b_gnt;
   logic          w_gnt;
   logic          w_we;
   logic          w_oor;
   logic [31:0]   w_addr;
   logic [DW-1:0] w_wdata;
   logic          w_a_own;
   logic          w_b_own;

   logic          r_rsp_pend;
   logic          r_rsp_owner;
   logic          r_rsp_err;
   logic          r_rsp_rd;

`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
   always_comb begin
      w_a_win = a_req & ~b_req;
      w_b_win = b_req;
   end
`else
   // r_ptr = 0 favours A, 1 favours B
   logic r_ptr;

   always_comb begin
      w_a_win = a_req & (~b_req | ~r_ptr);
      w_b_win = b_req & (~a_req | r_ptr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (w_a_gnt) begin
         r_ptr <= 1'b1;
      end else if (w_b_gnt) begin
         r_ptr <= 1'b0;
      end
   end
`endif

   // Grants are masked while reset is held so nothing leaks to memory.
   always_comb begin
      w_a_gnt = rst_n & w_a_win;
      w_b_gnt = rst_n & w_b_win;
      w_gnt   = w_a_gnt | w_b_gnt;
      w_we    = w_b_gnt ? b_we    : a_we;
      w_addr  = w_b_gnt ? b_addr  : a_addr;
      w_wdata = w_b_gnt ? b_wdata : a_wdata;
      w_oor   = |w_addr[31:AW];
   end

   always_comb begin
      a_gnt     = w_a_gnt;
      b_gnt     = w_b_gnt;
      mem_we    = 1'b0;
      mem_raddr = '0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (w_gnt && !w_oor) begin
         if (w_we) begin
            mem_we    = 1'b1;
            mem_waddr = w_addr;
            mem_wdata = w_wdata;
         end else begin
            mem_raddr = w_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_pend  <= 1'b0;
         r_rsp_owner <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rd    <= 1'b0;
      end else if (w_gnt) begin
         r_rsp_pend  <= ~w_we | w_oor;
         r_rsp_owner <= w_b_gnt;
         r_rsp_err   <= w_oor;
         r_rsp_rd    <= ~w_we;
      end else begin
         r_rsp_pend  <= 1'b0;
      end
   end

   always_comb begin
      w_a_own  = r_rsp_pend & ~r_rsp_owner;
      w_b_own  = r_rsp_pend & r_rsp_owner;
      a_rvalid = w_a_own & r_rsp_rd;
      b_rvalid = w_b_own & r_rsp_rd;
      a_err    = w_a_own & r_rsp_err;
      b_err    = w_b_own & r_rsp_err;
      a_rdata  = '0;
      b_rdata  = '0;
      if (a_rvalid && !r_rsp_err) begin
         a_rdata = mem_rdata;
      end
      if (b_rvalid && !r_rsp_err) begin
         b_rdata = mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, hand sequences and random traffic
// against a reference model with its own shadow memory.
module tb_mem_port_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int DEPTH = 2 ** AW;
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          a_req, b_req, a_we, b_we;
   logic [31:0]   a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          a_err, b_err, mem_we;
   logic [31:0]   mem_raddr, mem_waddr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt),
      .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
      .a_rdata(a_rdata), .b_rdata(b_rdata),
      .a_err(a_err), .b_err(b_err),
      .mem_we(mem_we), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(int i);
      return (i == 5) ? 32'h1234 : 32'(i * 3 + 7);
   endfunction

   // Memory attached to the DUT; filled with the pattern while mem_init is set.
   logic [DW-1:0] mem [DEPTH];
   logic          mem_init;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
         mem_rdata <= '0;
      end else begin
         if (mem_we) mem[mem_waddr[AW-1:0]] <= mem_wdata;
         mem_rdata <= mem[mem_raddr[AW-1:0]];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: favoured port, shadow memory, expected response.
   logic [DW-1:0] mm [DEPTH];
   bit            fav_b;
   bit            pv, pown_b, perr, prd;
   logic [DW-1:0] pdata;
   bit            m_ga, m_gb;
   bit            s_ag, s_bg, s_we, s_arv, s_brv, s_berr;
   logic [DW-1:0] s_ard, s_brd;

   task automatic model_reset();
      fav_b = 1'b0;
      pv    = 1'b0;
   endtask

   task automatic drive(bit ar, bit aw, logic [31:0] aa, logic [31:0] awd,
                        bit br, bit bw, logic [31:0] ba, logic [31:0] bwd);
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = awd;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bwd;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // One clock: check at negedge against the model, then advance the model.
   task automatic cycle();
      bit            ea, eb, g, we, oor, ewe, erd, ea_o, eb_o;
      logic [31:0]   ad;
      logic [DW-1:0] wd;
      @(negedge clk);
      ea  = a_req && (!b_req || !(FIXED || fav_b));
      eb  = b_req && !ea;
      g   = ea || eb;
      ad  = eb ? b_addr : a_addr;
      we  = eb ? b_we : a_we;
      wd  = eb ? b_wdata : a_wdata;
      oor = g && ((ad >> AW) != 0);
      ewe = g && we && !oor;
      erd = g && !we && !oor;
      ea_o = pv && !pown_b;
      eb_o = pv && pown_b;
      s_ag = a_gnt; s_bg = b_gnt; s_we = mem_we;
      s_arv = a_rvalid; s_ard = a_rdata;
      s_brv = b_rvalid; s_brd = b_rdata; s_berr = b_err;
      chk("a_gnt", a_gnt, ea);
      chk("b_gnt", b_gnt, eb);
      chk("mem_we", mem_we, ewe);
      chk("mem_waddr", mem_waddr, ewe ? ad : 0);
      chk("mem_wdata", mem_wdata, ewe ? wd : 0);
      chk("mem_raddr", mem_raddr, erd ? ad : 0);
      chk("a_rvalid", a_rvalid, ea_o && prd);
      chk("a_rdata", a_rdata, (ea_o && prd) ? pdata : 0);
      chk("a_err", a_err, ea_o && perr);
      chk("b_rvalid", b_rvalid, eb_o && prd);
      chk("b_rdata", b_rdata, (eb_o && prd) ? pdata : 0);
      chk("b_err", b_err, eb_o && perr);
      m_ga   = ea;
      m_gb   = eb;
      pv     = g && (!we || oor);
      pown_b = eb;
      perr   = oor;
      prd    = !we;
      pdata  = oor ? '0 : mm[ad[AW-1:0]];
      if (ewe) mm[ad[AW-1:0]] = wd;
      if (g && !FIXED) fav_b = ea;
      @(posedge clk);
      #1;
   endtask

   task automatic rst_chk(string tag);
      chk({tag, "_a_gnt"}, a_gnt, 0);
      chk({tag, "_b_gnt"}, b_gnt, 0);
      chk({tag, "_a_rvalid"}, a_rvalid, 0);
      chk({tag, "_b_rvalid"}, b_rvalid, 0);
      chk({tag, "_a_rdata"}, a_rdata, 0);
      chk({tag, "_b_rdata"}, b_rdata, 0);
      chk({tag, "_a_err"}, a_err, 0);
      chk({tag, "_b_err"}, b_err, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
   endtask

   function automatic logic [31:0] rnd_addr();
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) return $urandom;
      if (r == 1) return 32'h400 | 32'($urandom_range(0, 15));
      return 32'($urandom_range(0, 31));
   endfunction

   typedef struct {
      bit          ar, aw;
      logic [31:0] aa, awd;
      bit          br, bw;
      logic [31:0] ba, bwd;
      bit          xag, xbg, xwe, xarv;
      logic [31:0] xard;
      bit          xbrv;
      logic [31:0] xbrd;
      bit          xberr;
   } vec_t;

   vec_t tbl [10];
   bit   pa, pb, qaw, qbw;
   logic [31:0] qaa, qba, qawd, qbwd;

   initial begin
      tbl[0] = '{1,0,5,0,      0,0,0,0,          1,0,0, 0,0,      0,0,0};
      tbl[1] = '{0,0,0,0,      1,1,13,6,         0,1,1, 1,'h1234, 0,0,0};
      tbl[2] = '{1,0,13,0,     0,0,0,0,          1,0,0, 0,0,      0,0,0};
      tbl[3] = '{0,0,0,0,      0,0,0,0,          0,0,0, 1,6,      0,0,0};
      tbl[4] = '{0,0,0,0,      1,0,'h400,0,      0,1,0, 0,0,      0,0,0};
      tbl[5] = '{0,0,0,0,      1,1,'h400,'hdead, 0,1,0, 0,0,      1,0,1};
      tbl[6] = '{1,0,3,0,      0,0,0,0,          1,0,0, 0,0,      0,0,1};
      tbl[7] = '{1,0,1,0,      1,0,2,0,          0,1,0, 1,16,     0,0,0};
      tbl[8] = '{1,0,1,0,      0,0,0,0,          1,0,0, 0,0,      1,13,0};
      tbl[9] = '{0,0,0,0,      0,0,0,0,          0,0,0, 1,10,     0,0,0};

      for (int i = 0; i < DEPTH; i++) mm[i] = pat(i);
      model_reset();
      mem_init = 1'b1;
      rst_n = 1'b0;
      drive(1, 0, 5, 0, 1, 0, 6, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_chk("rst");
      mem_init = 1'b0;
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].awd,
               tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bwd);
         cycle();
         chk($sformatf("v%0d_a_gnt", i), s_ag, tbl[i].xag);
         chk($sformatf("v%0d_b_gnt", i), s_bg, tbl[i].xbg);
         chk($sformatf("v%0d_mem_we", i), s_we, tbl[i].xwe);
         chk($sformatf("v%0d_a_rvalid", i), s_arv, tbl[i].xarv);
         chk($sformatf("v%0d_a_rdata", i), s_ard, tbl[i].xard);
         chk($sformatf("v%0d_b_rvalid", i), s_brv, tbl[i].xbrv);
         chk($sformatf("v%0d_b_rdata", i), s_brd, tbl[i].xbrd);
         chk($sformatf("v%0d_b_err", i), s_berr, tbl[i].xberr);
      end
      chk("oor_write_mem0", mem[0], 7);
      chk("write_mem13", mem[13], 6);

      // Read granted, then reset before the response edge.
      drive(1, 0, 5, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("flight_a_gnt", a_gnt, 1);
      chk("flight_raddr", mem_raddr, 5);
      #2 rst_n = 1'b0;
      #1 idle();
      rst_chk("inrst");
      @(posedge clk);
      #1;
      rst_chk("inrst_edge");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      cycle();
      chk("flight_dropped", s_arv, 0);

      // Continuous contention: alternation, or B only when fixed.
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 20, 0, 1, 0, 21, 0);
         cycle();
         chk($sformatf("cont%0d_a_gnt", i), s_ag, !FIXED && (i % 2 == 0));
         chk($sformatf("cont%0d_b_gnt", i), s_bg, FIXED || (i % 2 == 1));
      end
      idle();
      cycle();

      pa = 0;
      pb = 0;
      for (int n = 0; n < 400; n++) begin
         if (!pa && $urandom_range(0, 2) != 0) begin
            pa = 1; qaw = 1'($urandom_range(0, 1));
            qaa = rnd_addr(); qawd = $urandom;
         end
         if (!pb && $urandom_range(0, 2) != 0) begin
            pb = 1; qbw = 1'($urandom_range(0, 1));
            qba = rnd_addr(); qbwd = $urandom;
         end
         drive(pa, qaw, qaa, qawd, pb, qbw, qba, qbwd);
         cycle();
         if (m_ga) pa = 0;
         if (m_gb) pb = 0;
      end
      idle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
